// File: rtl/ps2_keycode_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and the logic
// that consumes its keycodes.
package ps2_keycode_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_ok(input logic [7:0] data, input logic par,
                                    input logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the raw PS/2 lines, debounces the keyboard clock and flags
// each falling edge of the debounced clock as a bit event.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic sync_data,
  output logic bit_evt
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q, filt_d;
  logic          filt_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: defaults first, so no path through the block leaves a latch.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (clk_sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      filt_d = ~filt_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Idle PS/2 lines are high, so everything resets to 1 to avoid a fake edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking, so every flop samples the pre-edge values.
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
    end
  end

  assign sync_data = data_sync_q[1];
  assign bit_evt   = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver: deframes 11-bit frames, checks parity and
// stop bit, and keeps the last two received bytes for the movement logic.
module ps2_keycode_rx
  import ps2_keycode_rx_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = CLK_HZ / 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PS2Clk,
  input  logic        PS2Data,
  output logic [15:0] keycode,
  output logic        byte_strobe,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  logic sync_data;
  logic bit_evt;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk_i (PS2Clk),
    .ps2_data_i(PS2Data),
    .sync_data (sync_data),
    .bit_evt   (bit_evt)
  );

  ps2_state_t  state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [TW-1:0] tmo_q;
  logic [15:0] keycode_q;
  logic        byte_strobe_q;
  logic        frame_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      keycode_q     <= '0;
      byte_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      byte_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;

      if (state_q == ST_IDLE || bit_evt) begin
        tmo_q <= '0;
      end else if (tmo_q != TMO_MAX) begin
        tmo_q <= tmo_q + TW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (bit_evt && !sync_data) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (bit_evt) begin
            shift_q   <= {sync_data, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) state_q <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (bit_evt) begin
            parity_q <= sync_data;
            state_q  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_evt) begin
            state_q <= ST_IDLE;
            if (frame_ok(shift_q, parity_q, sync_data)) begin
              keycode_q     <= {keycode_q[7:0], shift_q};
              byte_strobe_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Abandon a stalled frame; returning to IDLE clears the counter, so
      // this fires once.
      if (state_q != ST_IDLE && !bit_evt && tmo_q == TMO_MAX) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
      end
    end
  end

  assign keycode     = keycode_q;
  assign byte_strobe = byte_strobe_q;
  assign frame_err   = frame_err_q;

endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter CLK_HZ SHALL default to 100_000_000: system clock frequency.
REQ-003 Parameter FILTER_LEN SHALL default to 8: consecutive agreeing samples needed to accept a PS2Clk level change.
REQ-004 Parameter TIMEOUT_CYC SHALL default to 200_000: clk cycles (2 ms) without a bit edge before a partial frame is abandoned.
REQ-005 Port clk SHALL be input, width 1: system clock, rising edge.
REQ-006 Port reset_n SHALL be input, width 1: asynchronous active-low reset.
REQ-007 Port PS2Clk SHALL be input, width 1: raw keyboard clock, asynchronous to clk.
REQ-008 Port PS2Data SHALL be input, width 1: raw keyboard data, asynchronous to clk.
REQ-009 Port keycode SHALL be output, width 16: {previous byte, latest byte}, consumed by the player-movement logic.
REQ-010 Port byte_strobe SHALL be output, width 1: one-cycle pulse when keycode updates.
REQ-011 Port frame_err SHALL be output, width 1: one-cycle pulse when a frame is discarded.

Function
REQ-012 PS2Clk and PS2Data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The filtered PS2Clk SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; shorter glitches SHALL be ignored.
REQ-014 A bit event SHALL be a 1-to-0 transition of filtered PS2Clk; synchronized PS2Data SHALL be sampled in that same cycle.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-016 In IDLE, a bit event with data 0 (start bit) SHALL go to DATA; a bit event with data 1 SHALL be ignored, stay IDLE, no frame_err.
REQ-017 DATA SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-018 PARITY SHALL capture the parity bit, then go to STOP.
REQ-019 On the STOP bit event the FSM SHALL return to IDLE.
REQ-020 The frame SHALL be valid only if data bits plus parity bit contain an odd number of ones and the stop bit is 1.
REQ-021 On a valid frame, keycode SHALL become {keycode[7:0], byte} and byte_strobe SHALL be high, both in the cycle after the stop-bit event.
REQ-022 On an invalid frame, keycode SHALL be unchanged and frame_err SHALL pulse in the cycle after the stop-bit event.
REQ-023 Outside IDLE, if TIMEOUT_CYC cycles elapse without a bit event, the FSM SHALL return to IDLE, discard partial data and pulse frame_err once.
REQ-024 The timeout counter SHALL clear on every bit event and while in IDLE, and SHALL saturate without wrapping.
REQ-025 byte_strobe and frame_err SHALL never be high in the same cycle, and neither SHALL be high for more than one cycle per frame.
REQ-026 Break (F0) and extended (E0) prefixes SHALL be passed through as ordinary bytes; the consumer interprets keycode[15:8].

Reset
REQ-027 While reset_n is 0: keycode = 16'h0000, byte_strobe = 0, frame_err = 0, FSM = IDLE, bit counter and timeout counter = 0, filtered clock = 1, synchronizers = 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef, FRAME_BITS = 11, and the keycode constants KEY_W = 8'h1D, KEY_A = 8'h1C, KEY_S = 8'h1B, KEY_D = 8'h23, KEY_BREAK = 8'hF0, KEY_EXT = 8'hE0.
REQ-030 Sub-module ps2_filter SHALL contain the synchronizers, glitch filter and falling-edge detector, and SHALL output sync_data and bit_evt.

Verification
REQ-031 After reset, send a frame for 0x1D with parity 1 and stop bit 1 -> one byte_strobe pulse; keycode = 16'h001D.
REQ-032 Then send 0xF0 (parity 1) followed by 0x1D (parity 1) -> two byte_strobe pulses; final keycode = 16'hF01D.
REQ-033 Send 0x1D with parity 0 -> frame_err pulses once; keycode unchanged; no byte_strobe.
REQ-034 Send start bit plus 5 data bits, then idle for TIMEOUT_CYC+10 cycles -> one frame_err; then send 0x29 (parity 0) -> keycode[7:0] = 8'h29.
REQ-035 Inject a 3-cycle low glitch on PS2Clk in IDLE with PS2Data = 0 -> FSM stays IDLE; no strobe; no error.
REQ-036 Assert reset_n = 0 after the 4th data bit of a frame, then release and send 0x1C (parity 0) -> no frame_err; keycode = 16'h001C.
